// File: rtl/spi_blob_pkg.sv
// rtl/spi_blob_pkg.sv - shared states and default timing constants for the SPI blob reader
//
// Purpose: one home for the reader FSM state encoding and the default
// SPI half-period / inter-frame gap lengths used by spi_blob_reader.
// Ports: none (package).

package spi_blob_pkg;

    // System-clock cycles per SPI clock half-period.
    localparam int DEFAULT_CLK_DIV    = 4;
    // Minimum spi_en-high cycles between frames (responder SDRAM fetch time).
    localparam int DEFAULT_GAP_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP,
        WAIT_OUT
    } state_t;

endpackage

// File: rtl/spi_shift8.sv
// rtl/spi_shift8.sv - 8-bit MOSI/MISO shift register for one SPI frame
//
// Purpose: holds the byte being shifted out (MSB first) and gathers the byte
// being shifted in. Strobes come from the reader FSM.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   load, load_data parallel load of the transmit byte (also clears rx_byte)
//   shift           advance the transmit byte by one bit
//   sample, miso    shift one received bit into rx_byte
//   mosi            current transmit bit (transmit register bit 7)
//   rx_byte         received byte, MSB first

module spi_shift8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    input  logic       sample,
    input  logic       miso,
    output logic       mosi,
    output logic [7:0] rx_byte
);

    logic [7:0] tx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg  <= 8'h00;
            rx_byte <= 8'h00;
        end else begin
            if (load) begin
                tx_reg  <= load_data;
                rx_byte <= 8'h00;
            end else begin
                if (shift) begin
                    tx_reg <= {tx_reg[6:0], 1'b0};
                end
                if (sample) begin
                    rx_byte <= {rx_byte[6:0], miso};
                end
            end
        end
    end

    assign mosi = tx_reg[7];

endmodule

// File: rtl/spi_blob_reader.sv
// rtl/spi_blob_reader.sv - SPI mode-0 master that reads a blob one byte per frame
//
// Purpose: on start, runs len SPI frames. Each frame sends cmd_byte on MOSI and
// captures one byte from MISO, which is offered on a single-register
// rx_data/rx_valid/rx_ready stream. A frame never starts while a byte is still
// waiting, and spi_en stays high at least GAP_CYCLES between frames.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   start, len, cmd_byte        transfer request (honoured only when idle)
//   busy, done                  transfer in progress / one-cycle completion pulse
//   rx_data, rx_valid, rx_ready received-byte stream
//   spi_en, spi_clk, spi_mosi   SPI master outputs (spi_en active-low select)
//   spi_miso                    SPI master input

module spi_blob_reader
    import spi_blob_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [7:0]  cmd_byte,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        spi_en,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int        GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [7:0]       div_cnt;
    logic [2:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      remaining;
    logic [7:0]       cmd_reg;

    logic       div_end;
    logic       gap_end;
    logic       accept;
    logic       frame_go;
    logic       hold_end;
    logic       sh_load;
    logic [7:0] sh_data;
    logic       sh_shift;
    logic       sh_sample;
    logic [7:0] rx_byte;

    // Strobes for the shift register. frame_go mirrors exactly the FSM
    // transitions into CS_SETUP so the command byte is in place (bit 7 on
    // MOSI) from the first cycle spi_en is low.
    always_comb begin
        div_end   = (div_cnt == DIV_LAST);
        gap_end   = (gap_cnt == GAP_LAST);
        accept    = rx_valid && rx_ready;
        hold_end  = (state == CS_HOLD) && div_end;
        frame_go  = 1'b0;
        sh_data   = 8'h00;
        sh_shift  = 1'b0;
        sh_sample = 1'b0;

        case (state)
            IDLE:     frame_go = start && (len != 16'd0);
            GAP:      frame_go = gap_end && !rx_valid && (remaining != 16'd0);
            WAIT_OUT: frame_go = (accept || !rx_valid) && (remaining != 16'd0);
            default:  frame_go = 1'b0;
        endcase

        if (frame_go) begin
            sh_data = (state == IDLE) ? cmd_byte : cmd_reg;
        end
        // Clearing the transmit register at frame end keeps MOSI low between frames.
        sh_load = frame_go || hold_end;

        // MISO is sampled on the edge that raises spi_clk; MOSI advances on
        // the edge that lowers it (not after the last bit).
        if (state == SHIFT && div_end) begin
            sh_sample = !spi_clk;
            sh_shift  = spi_clk && (bit_cnt != 3'd7);
        end
    end

    spi_shift8 u_shift8 (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (sh_data),
        .shift     (sh_shift),
        .sample    (sh_sample),
        .miso      (spi_miso),
        .mosi      (spi_mosi),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            gap_cnt   <= '0;
            remaining <= 16'd0;
            cmd_reg   <= 8'h00;
            spi_en    <= 1'b1;
            spi_clk   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != 16'd0) begin
                            remaining <= len;
                            cmd_reg   <= cmd_byte;
                            busy      <= 1'b1;
                            spi_en    <= 1'b0;
                            div_cnt   <= 8'd0;
                            state     <= CS_SETUP;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                CS_SETUP: begin
                    if (div_end) begin
                        div_cnt <= 8'd0;
                        bit_cnt <= 3'd0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                // spi_clk itself marks which half of the bit period we are in.
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= 8'd0;
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                        end else begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state <= CS_HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                // rx_valid is always low here (frames only start once the
                // previous byte has gone), so loading rx_data drops nothing.
                CS_HOLD: begin
                    if (div_end) begin
                        div_cnt   <= 8'd0;
                        spi_en    <= 1'b1;
                        rx_data   <= rx_byte;
                        rx_valid  <= 1'b1;
                        remaining <= remaining - 16'd1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (gap_end) begin
                        if (rx_valid) begin
                            state <= WAIT_OUT;
                        end else if (remaining == 16'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            spi_en  <= 1'b0;
                            div_cnt <= 8'd0;
                            state   <= CS_SETUP;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                WAIT_OUT: begin
                    if (accept || !rx_valid) begin
                        if (remaining == 16'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            spi_en  <= 1'b0;
                            div_cnt <= 8'd0;
                            state   <= CS_SETUP;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_blob_reader.sv
// tb/tb_spi_blob_reader.sv - self-checking bench for spi_blob_reader with an SPI responder model

module tb_spi_blob_reader;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 64;
    localparam int FRAME_LOW  = 18 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [7:0]  cmd_byte;
    logic        busy;
    logic        done;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        spi_en;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    always #5 clk = ~clk;

    spi_blob_reader #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .cmd_byte (cmd_byte),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .spi_en   (spi_en),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    int checks = 0;
    int errors = 0;

    // Monitor-owned state
    int frames_started, frames_done, frames_aborted, done_cnt;
    int bad_mosi, bad_len, bad_pulse, bad_high, bad_gap, bad_mosi_change, bad_done, bad_stable;
    int m_bit, m_pulses, m_low, m_high, m_clk_hi, slave_rd;
    logic m_have_prev;
    logic [7:0] m_cap, m_tx;
    logic prev_en, prev_clk, prev_mosi, prev_busy, prev_valid, prev_acc;
    logic [7:0] prev_data;
    logic [7:0] rx_q[$];

    // Main-owned state
    logic [7:0] slave_q[$];
    logic [7:0] exp_q[$];
    int exp_rd = 0;
    logic [7:0] exp_cmd = 8'h00;
    int ready_mode = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // rx_ready source: 0 = held low, 1 = held high, otherwise random each cycle.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // SPI responder model and protocol monitor, sampling on the falling clk edge.
    initial begin
        frames_started = 0; frames_done = 0; frames_aborted = 0; done_cnt = 0;
        bad_mosi = 0; bad_len = 0; bad_pulse = 0; bad_high = 0; bad_gap = 0;
        bad_mosi_change = 0; bad_done = 0; bad_stable = 0;
        m_bit = 0; m_pulses = 0; m_low = 0; m_high = 0; m_clk_hi = 0; slave_rd = 0;
        m_have_prev = 1'b0; m_cap = 8'h00; m_tx = 8'h00;
        prev_en = 1'b1; prev_clk = 1'b0; prev_mosi = 1'b0; prev_busy = 1'b0;
        prev_valid = 1'b0; prev_acc = 1'b0; prev_data = 8'h00;
        spi_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_en && !spi_en) begin
                frames_started++;
                if (m_have_prev && m_high < GAP_CYCLES) bad_gap++;
                m_tx = (slave_rd < slave_q.size()) ? slave_q[slave_rd] : 8'hEE;
                slave_rd++;
                m_bit = 0; m_pulses = 0; m_low = 0; m_cap = 8'h00; m_clk_hi = 0;
            end
            if (!prev_en && spi_en) begin
                if (m_pulses == 8) begin
                    frames_done++;
                    if (m_cap !== exp_cmd) bad_mosi++;
                    if (m_low != FRAME_LOW) bad_len++;
                    m_have_prev = 1'b1;
                end else if (rst) begin
                    frames_aborted++;
                end else begin
                    bad_pulse++;
                end
                m_high = 0;
            end
            if (!spi_en) begin
                m_low++;
                if (spi_clk && !prev_clk) begin
                    m_cap = {m_cap[6:0], spi_mosi};
                    m_bit++;
                    m_pulses++;
                end
                if (spi_clk) m_clk_hi++;
                if (!spi_clk && prev_clk) begin
                    if (m_clk_hi != CLK_DIV) bad_high++;
                    m_clk_hi = 0;
                end
                if (spi_clk && prev_clk && spi_mosi !== prev_mosi) bad_mosi_change++;
                if (!spi_clk && m_bit < 8) spi_miso = m_tx[7 - m_bit];
            end else begin
                m_high++;
                if (spi_clk) bad_pulse++;
            end
            if (done) begin
                done_cnt++;
                if (busy) bad_done++;
            end
            if (prev_busy && !busy && !done && !rst) bad_done++;
            if (prev_valid && !prev_acc && rx_valid && rx_data !== prev_data) bad_stable++;
            if (rx_valid && rx_ready) rx_q.push_back(rx_data);
            if (rst) m_have_prev = 1'b0;
            prev_en = spi_en; prev_clk = spi_clk; prev_mosi = spi_mosi; prev_busy = busy;
            prev_valid = rx_valid; prev_acc = rx_valid && rx_ready; prev_data = rx_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [7:0] c);
        @(posedge clk);
        #1;
        start = 1'b1; len = n; cmd_byte = c;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        slave_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int cyc = 0;
        while (done_cnt == base && cyc < budget) begin
            tick();
            cyc++;
        end
        check({tag, "_done_count"}, 64'(done_cnt - base), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_rx(input int rx0, input int n, input string tag);
        check({tag, "_rx_count"}, 64'(rx_q.size() - rx0), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (rx0 + i < rx_q.size()) check({tag, "_rx_byte"}, 64'(rx_q[rx0 + i]), 64'(exp_q[exp_rd + i]));
        end
        exp_rd += n;
    endtask

    task automatic run_xfer(input int n, input logic [7:0] c, input bit inject, input string tag);
        int fd0 = frames_done;
        int dc0 = done_cnt;
        int rx0 = rx_q.size();
        exp_cmd = c;
        do_start(16'(n), c);
        tick();
        check({tag, "_busy"}, 64'(busy), 64'd1);
        if (inject) begin
            repeat (100) @(posedge clk);
            #1;
            start = 1'b1; len = 16'd9; cmd_byte = 8'h00;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(dc0, 300 * n + 800, tag);
        check({tag, "_frames"}, 64'(frames_done - fd0), 64'(n));
        check_rx(rx0, n, tag);
    endtask

    initial begin
        int fs0, fd0, dc0, rx0, cyc, n;
        logic [7:0] c, b;
        rst = 1'b1; start = 1'b0; len = 16'd0; cmd_byte = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        tick();
        check("rst_spi_en", 64'(spi_en), 64'd1);
        check("rst_spi_clk", 64'(spi_clk), 64'd0);
        check("rst_spi_mosi", 64'(spi_mosi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three bytes, cmd A5, always ready
        ready_mode = 1;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        run_xfer(3, 8'hA5, 1'b0, "basic");

        // Random transfers with random back-pressure
        ready_mode = 2;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 4);
            c = 8'($urandom);
            for (int k = 0; k < n; k++) push_byte(8'($urandom));
            run_xfer(n, c, 1'b0, "random");
        end

        // Consumer stalls 500 cycles after the first byte
        ready_mode = 0;
        c = 8'($urandom);
        exp_cmd = c;
        push_byte(8'($urandom)); push_byte(8'($urandom));
        dc0 = done_cnt; rx0 = rx_q.size();
        do_start(16'd2, c);
        cyc = 0;
        while (!rx_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        check("stall_first_valid", 64'(rx_valid), 64'd1);
        fs0 = frames_started;
        repeat (500) tick();
        check("stall_no_new_frame", 64'(frames_started - fs0), 64'd0);
        check("stall_spi_en_high", 64'(spi_en), 64'd1);
        check("stall_valid_held", 64'(rx_valid), 64'd1);
        check("stall_data_held", 64'(rx_data), 64'(exp_q[exp_rd]));
        ready_mode = 1;
        wait_done(dc0, 1000, "stall");
        check_rx(rx0, 2, "stall");

        // len == 0: done next cycle, no frame, busy stays low
        fs0 = frames_started; dc0 = done_cnt;
        do_start(16'd0, 8'h5A);
        tick();
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        tick();
        check("len0_done_once", 64'(done), 64'd0);
        repeat (20) tick();
        check("len0_no_frame", 64'(frames_started - fs0), 64'd0);
        check("len0_done_count", 64'(done_cnt - dc0), 64'd1);

        // Reset in the middle of frame 2
        ready_mode = 1;
        c = 8'($urandom);
        exp_cmd = c;
        b = 8'($urandom);
        slave_q.push_back(b);
        slave_q.push_back(8'($urandom));
        fs0 = frames_started; rx0 = rx_q.size();
        do_start(16'd3, c);
        cyc = 0;
        while (!(frames_started - fs0 == 2 && m_bit == 4) && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("abort_reached_bit4", 64'(m_bit), 64'd4);
        rst = 1'b1;
        tick();
        check("abort_spi_en", 64'(spi_en), 64'd1);
        check("abort_spi_clk", 64'(spi_clk), 64'd0);
        check("abort_rx_valid", 64'(rx_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_rx_count", 64'(rx_q.size() - rx0), 64'd1);
        if (rx_q.size() > rx0) check("abort_first_byte", 64'(rx_q[rx0]), 64'(b));
        push_byte(8'($urandom));
        run_xfer(1, 8'($urandom), 1'b0, "after_rst");

        // Start pulsed mid-transfer is ignored
        push_byte(8'($urandom)); push_byte(8'($urandom));
        run_xfer(2, 8'h3C, 1'b1, "inject");

        // Protocol monitor tallies over the whole run
        check("mon_mosi", 64'(bad_mosi), 64'd0);
        check("mon_frame_len", 64'(bad_len), 64'd0);
        check("mon_pulses", 64'(bad_pulse), 64'd0);
        check("mon_clk_high", 64'(bad_high), 64'd0);
        check("mon_gap", 64'(bad_gap), 64'd0);
        check("mon_mosi_stable", 64'(bad_mosi_change), 64'd0);
        check("mon_done_busy", 64'(bad_done), 64'd0);
        check("mon_rx_stable", 64'(bad_stable), 64'd0);
        check("mon_aborted", 64'(frames_aborted), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_blob_reader.md
SPI_BLOB_READER -- requirements
Module: spi_blob_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: system-clock cycles per SPI clock half-period; legal range 2..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 64: minimum cycles spi_en stays high between frames, so the responder can fetch its next byte from SDRAM.
REQ-003 SHALL have port clk, input, 1: single system clock (clk100m domain); one clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a transfer; honoured only in IDLE.
REQ-006 SHALL have port len, input, 16: number of bytes to read, latched on an accepted start.
REQ-007 SHALL have port cmd_byte, input, 8: byte shifted out on MOSI in every frame, latched on an accepted start.
REQ-008 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a transfer completes.
REQ-010 SHALL have ports rx_data (output, 8), rx_valid (output, 1) and rx_ready (input, 1): received-byte stream; a byte transfers when rx_valid && rx_ready.
REQ-011 SHALL have ports spi_en (output, 1, active-low chip select), spi_clk (output, 1), spi_mosi (output, 1) and spi_miso (input, 1): SPI master pins.

Function
REQ-012 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first.
REQ-013 SHALL keep spi_clk idle low and change spi_mosi only while spi_clk is low.
REQ-014 SHALL sample spi_miso on the system-clock cycle in which spi_clk is driven high.
REQ-015 SHALL use these FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, WAIT_OUT.
REQ-016 IDLE: on start with len!=0, SHALL latch len and cmd_byte, assert busy and go to CS_SETUP.
REQ-017 IDLE: on start with len==0, SHALL pulse done in the next cycle, drive no spi_en activity, and leave busy low.
REQ-018 CS_SETUP: SHALL drive spi_en low and mosi = cmd bit7 for CLK_DIV cycles, then go to SHIFT.
REQ-019 SHIFT: SHALL run 8 bits, each CLK_DIV cycles with spi_clk low followed by CLK_DIV cycles with spi_clk high, then go to CS_HOLD with spi_clk low.
REQ-020 CS_HOLD: SHALL keep spi_en low for CLK_DIV cycles, then raise spi_en.
REQ-021 On leaving CS_HOLD, SHALL load the received byte into rx_data, set rx_valid, decrement the remaining count and go to GAP.
REQ-022 Frame length SHALL be 18*CLK_DIV cycles of spi_en low (72 at the default).
REQ-023 GAP: SHALL hold spi_en high for GAP_CYCLES, then:
  - remaining==0 and rx_valid==0 -> IDLE, with done pulsed;
  - remaining==0 and rx_valid==1 -> WAIT_OUT;
  - remaining>0 and rx_valid==0 -> CS_SETUP;
  - remaining>0 and rx_valid==1 -> WAIT_OUT.
REQ-024 WAIT_OUT: SHALL keep spi_en high until the byte is accepted, then go to CS_SETUP, or to IDLE with a done pulse when remaining==0.
REQ-025 rx_data/rx_valid SHALL be a single output register: rx_valid clears on accept and rx_data holds stable while valid.
REQ-026 A new frame SHALL never start while rx_valid is high, so no byte is ever dropped.
REQ-027 start asserted while busy SHALL be ignored, with no effect on latched len or cmd_byte.
REQ-028 done SHALL coincide with the cycle busy falls.
REQ-029 The remaining-byte counter SHALL be 16-bit, with no wrap: len=16'hFFFF reads exactly 65535 bytes.

Reset
REQ-030 SHALL bring all outputs to reset values in the cycle after rst is sampled high: spi_en=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rx_valid=0, rx_data=8'h00, state=IDLE.
REQ-031 rst asserted mid-frame SHALL abort the transfer, with spi_en high within 1 cycle and no partial byte delivered.
REQ-032 rst SHALL override start when both are asserted in the same cycle.

Structure
REQ-033 SHALL place the state enum and the default CLK_DIV/GAP_CYCLES constants in shared package spi_blob_pkg.
REQ-034 SHALL instantiate one sub-module, spi_shift8: an 8-bit MOSI/MISO shift register with load, shift and sample enables.
REQ-035 The half-period counter and the bit counter SHALL stay in the top FSM.

Verification
REQ-036 Scenario: len=3, cmd=8'hA5, slave model returns 8'h11, 8'h22, 8'h33, rx_ready=1 -> rx_data 11, 22, 33 in order; MOSI captured as A5 in every frame; one done pulse; busy low afterwards.
REQ-037 Scenario: CLK_DIV=4 timing -> spi_en low for exactly 72 cycles per frame; spi_en high >= 64 cycles between frames; spi_clk shows 8 pulses, each high 4 cycles.
REQ-038 Scenario: len=2, rx_ready held 0 for 500 cycles after the first byte -> no second frame starts; after release, byte 2 arrives intact and done follows.
REQ-039 Scenario: start with len=0 -> done pulses 1 cycle later; spi_en never low; busy stays 0.
REQ-040 Scenario: rst asserted during bit 4 of frame 2 -> next cycle spi_en=1, spi_clk=0, rx_valid=0; a subsequent start with len=1 works normally.
REQ-041 Scenario: start pulsed again mid-transfer with len=9, cmd=8'h00 -> ignored; the original len and cmd complete unchanged.
